// File: rtl/matvec_ctrl.sv
// Dense-layer sequencer: walks the row-major weight ROM, fetches activations and writes one
// saturated fixed-point dot product per output neuron. Define MATVEC_RELU_EN to clamp results at zero.
module matvec_ctrl #(
    parameter int IN_DIM    = 784,
    parameter int OUT_DIM   = 64,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          weight_addr,
    input  logic signed [DATA_W-1:0]   weight_data,
    output logic [$clog2(IN_DIM)-1:0]  in_addr,
    input  logic signed [DATA_W-1:0]   in_data,
    output logic [$clog2(OUT_DIM)-1:0] out_addr,
    output logic signed [DATA_W-1:0]   out_data,
    output logic                       out_we
);

    localparam int IW = $clog2(IN_DIM);
    localparam int OW = $clog2(OUT_DIM);
    localparam int AW = 2 * DATA_W;

    localparam logic [IW-1:0]        I_LAST    = IW'(IN_DIM - 1);
    localparam logic [OW-1:0]        J_LAST    = OW'(OUT_DIM - 1);
    localparam logic [ADDR_W-1:0]    ADDR_STEP = ADDR_W'(OUT_DIM);
    localparam logic [ADDR_W-1:0]    ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [IW-1:0]        I_ZERO    = {IW{1'b0}};
    localparam logic [OW-1:0]        J_ZERO    = {OW{1'b0}};
    localparam logic signed [AW-1:0] ACC_ZERO  = {AW{1'b0}};
    localparam logic signed [AW-1:0] SAT_MAX   = {{(DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN   = {{(DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Arithmetic shift back to the data format, then clamp to the signed DATA_W range.
    function automatic logic signed [DATA_W-1:0] scale_result(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0]     shifted;
        logic signed [DATA_W-1:0] res;
        shifted = acc >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            res = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            res = SAT_MIN[DATA_W-1:0];
        end else begin
            res = shifted[DATA_W-1:0];
        end
`ifdef MATVEC_RELU_EN
        if (res[DATA_W-1]) begin
            res = {DATA_W{1'b0}};
        end else begin
            res = res;
        end
`endif
        return res;
    endfunction

    state_t                   state_q, state_d;
    logic [IW-1:0]            i_q, i_d;
    logic [OW-1:0]            j_q, j_d;
    logic signed [AW-1:0]     acc_q, acc_d;
    logic signed [AW-1:0]     prod_q, prod_d;
    logic [ADDR_W-1:0]        weight_addr_q, weight_addr_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     out_we_q, out_we_d;
    logic [OW-1:0]            out_addr_q, out_addr_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;

    logic signed [AW-1:0] w_ext;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] mult;
    logic signed [AW-1:0] acc_sum;

    assign w_ext   = {{DATA_W{weight_data[DATA_W-1]}}, weight_data};
    assign x_ext   = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    assign mult    = w_ext * x_ext;
    assign acc_sum = acc_q + prod_q;

    // Next-state and next-output logic; outputs are computed one cycle ahead so they come straight from flops.
    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        acc_d         = acc_q;
        prod_d        = prod_q;
        weight_addr_d = weight_addr_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        out_we_d      = 1'b0;
        out_addr_d    = out_addr_q;
        out_data_d    = out_data_q;

        case (state_q)
            S_IDLE: begin
                i_d           = I_ZERO;
                j_d           = J_ZERO;
                acc_d         = ACC_ZERO;
                prod_d        = ACC_ZERO;
                weight_addr_d = ADDR_ZERO;
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_RUN: begin
                // The product lags the address by one cycle, so DRAIN folds in the last one.
                prod_d = mult;
                acc_d  = acc_sum;
                if (i_q == I_LAST) begin
                    state_d       = S_DRAIN;
                    i_d           = I_ZERO;
                    weight_addr_d = ADDR_ZERO;
                end else begin
                    i_d           = i_q + IW'(1'b1);
                    weight_addr_d = weight_addr_q + ADDR_STEP;
                end
            end
            S_DRAIN: begin
                acc_d      = acc_sum;
                state_d    = S_WRITE;
                out_we_d   = 1'b1;
                out_addr_d = j_q;
                out_data_d = scale_result(acc_sum);
            end
            S_WRITE: begin
                acc_d  = ACC_ZERO;
                prod_d = ACC_ZERO;
                if (j_q == J_LAST) begin
                    state_d       = S_DONE;
                    done_d        = 1'b1;
                    busy_d        = 1'b0;
                    weight_addr_d = ADDR_ZERO;
                end else begin
                    state_d       = S_RUN;
                    j_d           = j_q + OW'(1'b1);
                    weight_addr_d = ADDR_W'(j_q) + ADDR_W'(1'b1);
                end
            end
            S_DONE: begin
                state_d       = S_IDLE;
                j_d           = J_ZERO;
                weight_addr_d = ADDR_ZERO;
            end
            default: begin
                state_d       = S_IDLE;
                i_d           = I_ZERO;
                j_d           = J_ZERO;
                acc_d         = ACC_ZERO;
                prod_d        = ACC_ZERO;
                weight_addr_d = ADDR_ZERO;
                busy_d        = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            i_q           <= I_ZERO;
            j_q           <= J_ZERO;
            acc_q         <= ACC_ZERO;
            prod_q        <= ACC_ZERO;
            weight_addr_q <= ADDR_ZERO;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            out_we_q      <= 1'b0;
            out_addr_q    <= J_ZERO;
            out_data_q    <= {DATA_W{1'b0}};
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            acc_q         <= acc_d;
            prod_q        <= prod_d;
            weight_addr_q <= weight_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            out_we_q      <= out_we_d;
            out_addr_q    <= out_addr_d;
            out_data_q    <= out_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign weight_addr = weight_addr_q;
    assign in_addr     = i_q;
    assign out_addr    = out_addr_q;
    assign out_data    = out_data_q;
    assign out_we      = out_we_q;

endmodule
